// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  // Writeback result-mux select for this unit's result.
  localparam logic [1:0] WB_SEL_MULDIV = 2'b10;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIV  = 2'b10,
    OP_REM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Signed operand magnitude conversion and result negation for muldiv_unit.
// Instantiated only when MULDIV_SIGNED_EN is defined.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic                 is_signed_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [WIDTH-1:0]     a_mag_c_o,
  output logic [WIDTH-1:0]     b_mag_c_o,
  output logic                 neg_prod_c_o,
  output logic                 neg_quo_c_o,
  output logic                 neg_rem_c_o,
  input  logic                 neg_prod_i,
  input  logic                 neg_quo_i,
  input  logic                 neg_rem_i,
  input  logic [2*WIDTH-1:0]   prod_i,
  input  logic [WIDTH-1:0]     quo_i,
  input  logic [WIDTH-1:0]     rem_i,
  output logic [2*WIDTH-1:0]   prod_c_o,
  output logic [WIDTH-1:0]     quo_c_o,
  output logic [WIDTH-1:0]     rem_c_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic a_neg, b_neg, b_zero;

  assign a_neg  = is_signed_i & a_i[WIDTH-1];
  assign b_neg  = is_signed_i & b_i[WIDTH-1];
  assign b_zero = (b_i == '0);

  assign a_mag_c_o = a_neg ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag_c_o = b_neg ? (~b_i + WIDTH'(1)) : b_i;

  // Divide by zero keeps the raw all-ones quotient regardless of signs.
  assign neg_prod_c_o = a_neg ^ b_neg;
  assign neg_quo_c_o  = (a_neg ^ b_neg) & ~b_zero;
  assign neg_rem_c_o  = a_neg;

  assign prod_c_o = neg_prod_i ? (~prod_i + PW'(1))    : prod_i;
  assign quo_c_o  = neg_quo_i  ? (~quo_i  + WIDTH'(1)) : quo_i;
  assign rem_c_o  = neg_rem_i  ? (~rem_i  + WIDTH'(1)) : rem_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit with start/busy/done handshake.
// Define MULDIV_SIGNED_EN to honour is_signed; otherwise all operations are unsigned.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  op_e              op_q;
  logic [WIDTH-1:0] acc_q, lo_q, b_q;
  logic [WIDTH-1:0] acc_d, lo_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] result_q;

  logic             accept_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0] quo_c, rem_c, res_c;
  logic [WIDTH:0]   mul_sum_c, div_shift_c;
  logic             is_mul_c;

  assign accept_c = (state_q == ST_IDLE) && start && !flush;
  assign is_mul_c = (op_q == OP_MUL) || (op_q == OP_MULH);

  // One shift-add or restoring shift-subtract step; {acc_q, lo_q} is the working pair.
  always_comb begin
    acc_d       = acc_q;
    lo_d        = lo_q;
    mul_sum_c   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift_c = {acc_q, lo_q[WIDTH-1]};
    if (is_mul_c) begin
      acc_d = mul_sum_c[WIDTH:1];
      lo_d  = {mul_sum_c[0], lo_q[WIDTH-1:1]};
    end else if (div_shift_c >= {1'b0, b_q}) begin
      acc_d = div_shift_c[WIDTH-1:0] - b_q;
      lo_d  = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = div_shift_c[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

`ifdef MULDIV_SIGNED_EN
  logic neg_prod_q, neg_quo_q, neg_rem_q;
  logic neg_prod_c, neg_quo_c, neg_rem_c;

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .is_signed_i  (is_signed),
    .a_i          (a),
    .b_i          (b),
    .a_mag_c_o    (a_mag_c),
    .b_mag_c_o    (b_mag_c),
    .neg_prod_c_o (neg_prod_c),
    .neg_quo_c_o  (neg_quo_c),
    .neg_rem_c_o  (neg_rem_c),
    .neg_prod_i   (neg_prod_q),
    .neg_quo_i    (neg_quo_q),
    .neg_rem_i    (neg_rem_q),
    .prod_i       ({acc_d, lo_d}),
    .quo_i        (lo_d),
    .rem_i        (acc_d),
    .prod_c_o     (prod_c),
    .quo_c_o      (quo_c),
    .rem_c_o      (rem_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (accept_c) begin
      neg_prod_q <= neg_prod_c;
      neg_quo_q  <= neg_quo_c;
      neg_rem_q  <= neg_rem_c;
    end
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign a_mag_c = a;
  assign b_mag_c = b;
  assign prod_c  = {acc_d, lo_d};
  assign quo_c   = lo_d;
  assign rem_c   = acc_d;
`endif

  always_comb begin
    res_c = rem_c;
    unique case (op_q)
      OP_MUL:  res_c = prod_c[WIDTH-1:0];
      OP_MULH: res_c = prod_c[2*WIDTH-1:WIDTH];
      OP_DIV:  res_c = quo_c;
      default: res_c = rem_c;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            op_q    <= op_e'(op);
            acc_q   <= '0;
            lo_q    <= a_mag_c;
            b_q     <= b_mag_c;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              result_q <= res_c;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, flush, is_signed;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  int           n_pass  = 0;
  int           n_total = 0;
  logic [W-1:0] last_res;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .op        (op),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic s);
    logic [63:0] p;
    longint      sx, sy;
    bit          sg, ovf;
    sg  = s && SIGNED_BUILD;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (sg) p = 64'(sx * sy);
    else    p = {32'b0, x} * {32'b0, y};
    case (o)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (y == 0) return '1;
        if (sg) return ovf ? 32'h8000_0000 : 32'(sx / sy);
        return x / y;
      end
      default: begin
        if (y == 0) return x;
        if (sg) return ovf ? 32'h0 : 32'(sx % sy);
        return x % y;
      end
    endcase
  endfunction

  // Launch one operation from IDLE and collect its observable behaviour.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic s, output logic [W-1:0] res, output int lat,
                        output logic busy0, output logic done_after, output logic busy_after);
    start = 1'b1; op = o; a = x; b = y; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); is_signed = 1'($urandom);
    busy0 = busy;
    lat = 0;
    while (!done && lat < int'(W) + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    @(posedge clk); #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; a = '0; b = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0)  $display("FAIL reset busy: got %b expected 0", busy);   else n_pass++;
    n_total++; if (done !== 1'b0)  $display("FAIL reset done: got %b expected 0", done);   else n_pass++;
    n_total++; if (result !== '0)  $display("FAIL reset result: got %h expected 0", result); else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0)  $display("FAIL idle busy: got %b expected 0", busy);   else n_pass++;
    n_total++; if (done !== 1'b0)  $display("FAIL idle done: got %b expected 0", done);   else n_pass++;
    last_res = '0;
  endtask

  task automatic test_directed();
    logic [1:0]   t_op [6];
    logic [W-1:0] t_a [6], t_b [6], t_exp [6];
    logic [W-1:0] res;
    int           lat;
    logic         b0, da, ba;
    t_op  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3};
    t_a   = '{32'h0000_1234, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h1234, 32'h1234};
    t_b   = '{32'h0000_5678, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'h0, 32'h0};
    t_exp = '{32'h0626_0060, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234};
    for (int i = 0; i < 6; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b0, res, lat, b0, da, ba);
      n_total++; if (res !== t_exp[i]) $display("FAIL directed[%0d] result: got %h expected %h", i, res, t_exp[i]); else n_pass++;
      n_total++; if (lat != int'(W))   $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, W); else n_pass++;
      n_total++; if (b0 !== 1'b1)      $display("FAIL directed[%0d] busy after start: got %b expected 1", i, b0); else n_pass++;
      n_total++; if (da !== 1'b0)      $display("FAIL directed[%0d] done width: got %b expected 0", i, da); else n_pass++;
      n_total++; if (ba !== 1'b0)      $display("FAIL directed[%0d] busy after done: got %b expected 0", i, ba); else n_pass++;
      last_res = t_exp[i];
    end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] x, y, res, exp;
    int           lat;
    logic         b0, da, ba;
    start = 1'b1; op = 2'd0; a = 32'h0001_0003; b = 32'h0002_0005; is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_total++; if (busy !== 1'b0) $display("FAIL async reset busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL async reset done: got %b expected 0", done); else n_pass++;
    n_total++; if (result !== '0) $display("FAIL async reset result: got %h expected 0", result); else n_pass++;
    @(negedge clk); reset = 1'b0;
    last_res = '0;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0) $display("FAIL post reset busy: got %b expected 0", busy); else n_pass++;
    x = $urandom; y = $urandom;
    exp = ref_model(2'd0, x, y, 1'b0);
    run_op(2'd0, x, y, 1'b0, res, lat, b0, da, ba);
    n_total++; if (res !== exp) $display("FAIL post reset MUL: got %h expected %h", res, exp); else n_pass++;
    n_total++; if (lat != int'(W)) $display("FAIL post reset latency: got %0d expected %0d", lat, W); else n_pass++;
    last_res = exp;
  endtask

  task automatic test_random();
    logic [1:0]   o;
    logic [W-1:0] x, y, res, exp;
    logic         s, b0, da, ba;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 4))
        0:       y = '0;
        1:       y = W'($urandom_range(1, 255));
        2:       y = '1;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
      s = 1'($urandom);
      exp = ref_model(o, x, y, s);
      run_op(o, x, y, s, res, lat, b0, da, ba);
      n_total++; if (res !== exp) $display("FAIL random[%0d] op=%0d s=%b a=%h b=%h: got %h expected %h", i, o, s, x, y, res, exp); else n_pass++;
      n_total++; if (lat != int'(W)) $display("FAIL random[%0d] latency: got %0d expected %0d", i, lat, W); else n_pass++;
      last_res = exp;
    end
  endtask

  task automatic test_back_to_back();
    logic         bz [40];
    logic [W-1:0] x, y, exp, res1;
    int           dcount, didx, waited;
    x = $urandom; y = $urandom;
    exp = ref_model(2'd1, x, y, 1'b0);
    dcount = 0; didx = -1; res1 = '0;
    start = 1'b1; op = 2'd1; a = x; b = y; is_signed = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      bz[i] = busy;
      if (done) begin
        dcount++;
        if (didx < 0) begin didx = i; res1 = result; end
      end
    end
    start = 1'b0;
    n_total++; if (dcount != 1) $display("FAIL b2b done count: got %0d expected 1", dcount); else n_pass++;
    n_total++; if (didx != int'(W)) $display("FAIL b2b done cycle: got %0d expected %0d", didx, W); else n_pass++;
    n_total++; if (res1 !== exp) $display("FAIL b2b result: got %h expected %h", res1, exp); else n_pass++;
    n_total++; if (bz[W+1] !== 1'b0) $display("FAIL b2b busy cycle after done: got %b expected 0", bz[W+1]); else n_pass++;
    n_total++; if (bz[W+2] !== 1'b1) $display("FAIL b2b restart busy: got %b expected 1", bz[W+2]); else n_pass++;
    waited = 0;
    while (!done && waited < 60) begin @(posedge clk); #1; waited++; end
    n_total++; if (done !== 1'b1) $display("FAIL b2b second done: got %b expected 1", done); else n_pass++;
    n_total++; if (result !== exp) $display("FAIL b2b second result: got %h expected %h", result, exp); else n_pass++;
    last_res = exp;
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic seen;
    start = 1'b1; op = 2'd2; a = $urandom; b = W'($urandom_range(1, 1000)); is_signed = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush busy: got %b expected 0", busy); else n_pass++;
    n_total++; if (result !== last_res) $display("FAIL flush result: got %h expected %h", result, last_res); else n_pass++;
    seen = 1'b0;
    repeat (W + 4) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    n_total++; if (seen !== 1'b0) $display("FAIL flush activity: got %b expected 0", seen); else n_pass++;
    n_total++; if (result !== last_res) $display("FAIL flush result held: got %h expected %h", result, last_res); else n_pass++;
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL flush+start busy: got %b expected 0", busy); else n_pass++;
    seen = 1'b0;
    repeat (W + 4) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    n_total++; if (seen !== 1'b0) $display("FAIL flush+start activity: got %b expected 0", seen); else n_pass++;
    n_total++; if (result !== last_res) $display("FAIL flush+start result: got %h expected %h", result, last_res); else n_pass++;
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    logic [1:0]   t_op [7];
    logic [W-1:0] t_a [7], t_b [7], t_exp [7];
    logic [W-1:0] res;
    int           lat;
    logic         b0, da, ba;
    t_op  = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    t_a   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    t_b   = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    t_exp = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    for (int i = 0; i < 7; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], 1'b1, res, lat, b0, da, ba);
      n_total++; if (res !== t_exp[i]) $display("FAIL signed[%0d] result: got %h expected %h", i, res, t_exp[i]); else n_pass++;
      n_total++; if (lat != int'(W))   $display("FAIL signed[%0d] latency: got %0d expected %0d", i, lat, W); else n_pass++;
      last_res = t_exp[i];
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_reset_midrun();
    test_random();
    test_back_to_back();
    test_flush();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
